rv32_imm_sched: RTL and testbench

- Round-robin scheduler that shares one rv32_imm_gen instance among NUM_HARTS instruction requesters (one per hart in the barrel core).
- Each cycle it grants at most one requester and feeds that requester's instruction to the shared immediate generator.
- It registers the decoded immediate, tagged with the hart id, into a single-entry output stage with valid/ready backpressure.
- Sits between the per-hart fetch/decode slots and the execute-stage operand mux.

---
 rtl/rv32_imm_sched.sv | 176 +++++++++++++++++
 tb/tb_rv32_imm_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_imm_sched.sv
//------------------------------------------------------------------------------
// Module   : rv32_imm_sched (with rv32_imm_gen)
// Brief    : Round-robin arbiter sharing one RV32 immediate generator among
//            NUM_HARTS requesters; single-entry registered output stage.
//            Optional counters: define RV32_IMM_SCHED_STATS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module rv32_imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] imm
);
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_system = 7'b1110011;

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_z;

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_imm_z = {27'b0, instr[19:15]};

    always_comb begin
        imm = '0;
        case (instr[6:0])
            c_op_lui, c_op_auipc:            imm = w_imm_u;
            c_op_jal:                        imm = w_imm_j;
            c_op_jalr, c_op_load, c_op_opimm: imm = w_imm_i;
            c_op_branch:                     imm = w_imm_b;
            c_op_store:                      imm = w_imm_s;
            // CSR immediate forms (funct3[2]=1) carry zimm; register forms expose the CSR address
            c_op_system:                     imm = instr[14] ? w_imm_z : w_imm_i;
            default:                         imm = '0;
        endcase
    end
endmodule

module rv32_imm_sched #(
    parameter  int NUM_HARTS = 8,
    localparam int HART_W    = $clog2(NUM_HARTS),
    localparam int XLEN      = `XPR_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_HARTS-1:0]      req_valid,
    input  logic [NUM_HARTS*XLEN-1:0] req_instr,
    output logic [NUM_HARTS-1:0]      req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [HART_W-1:0]         out_hart,
    output logic [XLEN-1:0]           out_instr,
    output logic [XLEN-1:0]           out_imm
`ifdef RV32_IMM_SCHED_STATS_EN
    ,
    output logic [31:0]               grant_cnt,
    output logic [31:0]               stall_cnt
`endif
);
    logic                r_out_valid;
    logic [HART_W-1:0]   r_out_hart;
    logic [XLEN-1:0]     r_out_instr;
    logic [XLEN-1:0]     r_out_imm;
    logic [HART_W-1:0]   r_rr_ptr;

    logic                w_can_load;
    logic                w_grant_en;
    logic [HART_W-1:0]   w_grant_idx;
    logic [HART_W-1:0]   w_next_ptr;
    logic [XLEN-1:0]     w_instr_arr [NUM_HARTS];
    logic [XLEN-1:0]     w_grant_instr;
    logic [XLEN-1:0]     w_grant_imm;

    genvar h;
    generate
        for (h = 0; h < NUM_HARTS; h++) begin : g_unpack
            assign w_instr_arr[h] = req_instr[h*XLEN +: XLEN];
        end
    endgenerate

    assign w_can_load = !r_out_valid || out_ready;
    assign w_grant_en = w_can_load && (|req_valid) && !rst;

    // Rotating priority: first valid requester at or after r_rr_ptr wins
    always_comb begin
        logic hit;
        int   pos;
        hit         = 1'b0;
        pos         = 0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            pos = int'(r_rr_ptr) + k;
            if (pos >= NUM_HARTS) begin
                pos = pos - NUM_HARTS;
            end
            if (!hit && req_valid[pos[HART_W-1:0]]) begin
                hit         = 1'b1;
                w_grant_idx = pos[HART_W-1:0];
            end
        end
    end

    assign w_next_ptr    = (w_grant_idx == HART_W'(NUM_HARTS - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_grant_instr = w_instr_arr[w_grant_idx];
    assign req_ready     = w_grant_en ? (NUM_HARTS'(1) << w_grant_idx) : '0;

    rv32_imm_gen u_imm_gen (
        .instr (w_grant_instr),
        .imm   (w_grant_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_hart  <= '0;
            r_out_instr <= '0;
            r_out_imm   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant_en) begin
            r_out_valid <= 1'b1;
            r_out_hart  <= w_grant_idx;
            r_out_instr <= w_grant_instr;
            r_out_imm   <= w_grant_imm;
            r_rr_ptr    <= w_next_ptr;
        end else if (w_can_load) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_hart  = r_out_hart;
    assign out_instr = r_out_instr;
    assign out_imm   = r_out_imm;

`ifdef RV32_IMM_SCHED_STATS_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant_en) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
            if ((|req_valid) && !w_can_load) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign stall_cnt = r_stall_cnt;
`endif
endmodule

`default_nettype wire

// File: tb/tb_rv32_imm_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_rv32_imm_sched
// Brief    : Directed self-checking bench for rv32_imm_sched (8 harts).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv32_imm_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   req_valid;
    logic [255:0] req_instr;
    logic [7:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_hart;
    logic [31:0]  out_instr;
    logic [31:0]  out_imm;
`ifdef RV32_IMM_SCHED_STATS_EN
    logic [31:0]  grant_cnt;
    logic [31:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_imm_sched #(.NUM_HARTS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_instr (req_instr),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hart  (out_hart),
        .out_instr (out_instr),
        .out_imm   (out_imm)
`ifdef RV32_IMM_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input int hart, input logic [31:0] v);
        req_instr[hart*32 +: 32] = v;
    endtask

    logic [31:0] vec_instr [5];
    logic [31:0] vec_imm   [5];

    initial begin
        vec_instr[0] = 32'h123450B7; vec_imm[0] = 32'h12345000; // lui
        vec_instr[1] = 32'hFE20AC23; vec_imm[1] = 32'hFFFFFFF8; // sw -8
        vec_instr[2] = 32'h008000EF; vec_imm[2] = 32'h00000008; // jal +8
        vec_instr[3] = 32'h3002D073; vec_imm[3] = 32'h00000005; // csrrwi zimm 5
        vec_instr[4] = 32'hFFF00093; vec_imm[4] = 32'hFFFFFFFF; // addi -1

        rst       = 1'b1;
        req_valid = 8'hFF;
        req_instr = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("ready_in_rst", {24'b0, req_ready}, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_imm", out_imm, 32'h0);
        check("rst_hart", {29'b0, out_hart}, 32'h0);
        req_valid = 8'h00;
        rst       = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", {31'b0, out_valid}, 32'h0);
            check("idle_ready", {24'b0, req_ready}, 32'h0);
            check("idle_imm", out_imm, 32'h0);
        end

        // single request, hart 3
        set_instr(3, 32'h00500093);
        req_valid = 8'b0000_1000;
        settle();
        check("single_ready", {24'b0, req_ready}, 32'h08);
        tick();
        req_valid = 8'h00;
        check("single_valid", {31'b0, out_valid}, 32'h1);
        check("single_hart", {29'b0, out_hart}, 32'd3);
        check("single_imm", out_imm, 32'h5);
        check("single_instr", out_instr, 32'h00500093);

        // pointer now 4: of harts 2 and 5, hart 5 must win
        set_instr(2, 32'h00100093);
        set_instr(5, 32'h00600093);
        req_valid = 8'b0010_0100;
        settle();
        check("ptr4_ready", {24'b0, req_ready}, 32'h20);
        tick();
        req_valid = 8'h00;
        check("ptr4_hart", {29'b0, out_hart}, 32'd5);
        check("ptr4_imm", out_imm, 32'h6);
        tick();
        check("drain_valid", {31'b0, out_valid}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            set_instr(4, vec_instr[i]);
            req_valid = 8'b0001_0000;
            settle();
            check("vec_ready", {24'b0, req_ready}, 32'h10);
            tick();
            check("vec_imm", out_imm, vec_imm[i]);
            check("vec_instr", out_instr, vec_instr[i]);
        end
        req_valid = 8'h00;

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // all harts valid: lui x1, h
        for (int h = 0; h < 8; h++) begin
            set_instr(h, 32'h000000B7 | (h << 12));
        end
        req_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] exp_rdy;
            exp_rdy = 8'd1 << (k % 8);
            settle();
            check("rr_ready", {24'b0, req_ready}, {24'b0, exp_rdy});
            tick();
            check("rr_valid", {31'b0, out_valid}, 32'h1);
            check("rr_hart", {29'b0, out_hart}, k % 8);
            check("rr_imm", out_imm, (k % 8) << 12);
        end
        req_valid = 8'h00;
        tick();
        check("rr_drain", {31'b0, out_valid}, 32'h0);

        // backpressure: pointer at 1, hart 2 beq -4
        set_instr(2, 32'hFE000EE3);
        req_valid = 8'b0000_0100;
        settle();
        check("bp_grant", {24'b0, req_ready}, 32'h04);
        tick();
        set_instr(5, 32'h00700093);
        req_valid = 8'b0010_0000;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_ready", {24'b0, req_ready}, 32'h0);
            tick();
            check("bp_valid", {31'b0, out_valid}, 32'h1);
            check("bp_hart", {29'b0, out_hart}, 32'd2);
            check("bp_imm", out_imm, 32'hFFFFFFFC);
        end
        out_ready = 1'b1;
        settle();
        check("bp_release", {24'b0, req_ready}, 32'h20);
        tick();
        req_valid = 8'h00;
        check("bp_next_hart", {29'b0, out_hart}, 32'd5);
        check("bp_next_imm", out_imm, 32'h7);

        // move pointer to 7 via hart 6, then harts 7 and 1
        set_instr(6, 32'h00800093);
        req_valid = 8'b0100_0000;
        tick();
        set_instr(7, 32'h00900093);
        set_instr(1, 32'h00A00093);
        req_valid = 8'b1000_0010;
        settle();
        check("wrap_ready7", {24'b0, req_ready}, 32'h80);
        tick();
        check("wrap_hart7", {29'b0, out_hart}, 32'd7);
        req_valid = 8'b0000_0010;
        settle();
        check("wrap_ready1", {24'b0, req_ready}, 32'h02);
        tick();
        check("wrap_hart1", {29'b0, out_hart}, 32'd1);
        check("wrap_imm1", out_imm, 32'hA);

        // reset while holding an entry
        req_valid = 8'h00;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("midrst_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_imm", out_imm, 32'h0);
        req_valid = 8'b0010_0001;
        settle();
        check("midrst_ptr", {24'b0, req_ready}, 32'h01);
        tick();
        req_valid = 8'h00;
        tick();

`ifdef RV32_IMM_SCHED_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stats_rst_g", grant_cnt, 32'd0);
        check("stats_rst_s", stall_cnt, 32'd0);
        req_valid = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("stats_grant", grant_cnt, 32'd10);
        check("stats_stall", stall_cnt, 32'd4);
        req_valid = 8'h00;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        check("stats_clr_g", grant_cnt, 32'd0);
        check("stats_clr_s", stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
